hazard_ctrl: RTL

//  Pipeline control unit for the 5-stage core; drives the 2-bit ctr input of the
//  IF/ID, ID/EX, EX/MEM and MEM/WB latch instances (00 normal, 01 squash, 10 stall).

---
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard detection inputs and pipeline latch controls for hazard_ctrl.
// The slave side is the control unit; the master side is whoever drives the pipeline status.
interface hazard_ctrl_if #(
   parameter int REGW = 5,
   parameter int CNTW = 32
);
   logic [REGW-1:0] id_rs1_i;
   logic [REGW-1:0] id_rs2_i;
   logic            id_use_rs1_i;
   logic            id_use_rs2_i;
   logic            ex_is_load_i;
   logic [REGW-1:0] ex_rd_i;
   logic            ex_br_taken_i;
   logic            ex_mc_start_i;
   logic            mem_wait_i;
   logic            perf_clr_i;

   logic [1:0]      ctr_ifid_o;
   logic [1:0]      ctr_idex_o;
   logic [1:0]      ctr_exmem_o;
   logic [1:0]      ctr_memwb_o;
   logic            pc_hold_o;
   logic            mc_busy_o;
   logic [CNTW-1:0] stall_cnt_o;

   modport slave (
      input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
      input  ex_is_load_i, ex_rd_i, ex_br_taken_i, ex_mc_start_i,
      input  mem_wait_i, perf_clr_i,
      output ctr_ifid_o, ctr_idex_o, ctr_exmem_o, ctr_memwb_o,
      output pc_hold_o, mc_busy_o, stall_cnt_o
   );

   modport master (
      output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
      output ex_is_load_i, ex_rd_i, ex_br_taken_i, ex_mc_start_i,
      output mem_wait_i, perf_clr_i,
      input  ctr_ifid_o, ctr_idex_o, ctr_exmem_o, ctr_memwb_o,
      input  pc_hold_o, mc_busy_o, stall_cnt_o
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline control unit for the 5-stage core: load-use, branch flush, memory wait,
// multi-cycle EX op sequencing, and a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int REGW      = 5,
   parameter int MC_CYCLES = 8,
   parameter int CNTW      = 32
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);
   localparam int CW = $clog2(MC_CYCLES);

   localparam logic [1:0] CTR_NORM  = 2'b00;
   localparam logic [1:0] CTR_SQUSH = 2'b01;
   localparam logic [1:0] CTR_STALL = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CNTW-1:0] stall_q, stall_d;

   logic [REGW-1:0] ex_rd;
   logic            load_use;
   logic            mc_start_ok;
   logic            mc_stall;
   logic [1:0]      ifid, idex, exmem, memwb;
   logic            pc_hold;

   assign ex_rd = hz.ex_rd_i;

   // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
   assign load_use = hz.ex_is_load_i && (ex_rd != '0) &&
                     ((hz.id_use_rs1_i && (hz.id_rs1_i == ex_rd)) ||
                      (hz.id_use_rs2_i && (hz.id_rs2_i == ex_rd)));

   // A taken branch in EX kills a multi-cycle request in the same cycle.
   assign mc_start_ok = (state_q == ST_IDLE) && hz.ex_mc_start_i && !hz.ex_br_taken_i;
   assign mc_stall    = mc_start_ok || ((state_q == ST_BUSY) && (cnt_q != '0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (mc_start_ok) begin
               state_d = ST_BUSY;
               cnt_d   = CW'(MC_CYCLES - 2);
            end
         end
         ST_BUSY: begin
            // The count runs down regardless of mem_wait; only the release waits.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else if (!hz.mem_wait_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!hz.mem_wait_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      ifid  = CTR_NORM;
      idex  = CTR_NORM;
      exmem = CTR_NORM;
      memwb = CTR_NORM;
      if (!rst) begin
         ifid  = CTR_SQUSH;
         idex  = CTR_SQUSH;
         exmem = CTR_SQUSH;
         memwb = CTR_SQUSH;
      end else if (hz.mem_wait_i) begin
         ifid  = CTR_STALL;
         idex  = CTR_STALL;
         exmem = CTR_STALL;
         memwb = CTR_STALL;
      end else if (mc_stall) begin
         // Hold IF/ID/EX while the op iterates; MEM sees a bubble each cycle.
         ifid  = CTR_STALL;
         idex  = CTR_STALL;
         exmem = CTR_SQUSH;
      end else if (hz.ex_br_taken_i) begin
         ifid  = CTR_SQUSH;
         idex  = CTR_SQUSH;
      end else if (load_use) begin
         ifid  = CTR_STALL;
         idex  = CTR_SQUSH;
      end
   end

   assign pc_hold = (ifid == CTR_STALL);

   always_comb begin
      stall_d = stall_q;
      if (hz.perf_clr_i) begin
         stall_d = '0;
      end else if (pc_hold && (stall_q != '1)) begin
         stall_d = stall_q + CNTW'(1);
      end
   end

   assign hz.ctr_ifid_o  = ifid;
   assign hz.ctr_idex_o  = idex;
   assign hz.ctr_exmem_o = exmem;
   assign hz.ctr_memwb_o = memwb;
   assign hz.pc_hold_o   = pc_hold;
   assign hz.mc_busy_o   = rst && (state_q != ST_IDLE);
   assign hz.stall_cnt_o = stall_q;
endmodule
